// File: rtl/uart_rx_deserializer.sv
// 8N1-style UART receiver: oversampled start detect, mid-bit sampling, LSB-first shift,
// one-clock rx_valid / framing_error strobes, and break hold-off until the line idles.
//   state    | meaning
//   ST_IDLE  | line idle, waiting for a low sample
//   ST_START | counting to mid start bit to confirm it
//   ST_DATA  | sampling data bits every OVERSAMPLE ticks
//   ST_STOP  | sampling the stop bit
//   ST_BREAK | stop bit was low; wait for the line to return high
module uart_rx_deserializer #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_enable,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 framing_error,
  output logic                 rx_busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS) + 1;
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_BREAK} state_t;

  state_t               state, state_nxt;
  logic [TW-1:0]        tick_cnt, tick_nxt;
  logic [BW-1:0]        bit_cnt, bit_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic [DATA_BITS-1:0] data_nxt;
  logic                 valid_nxt, ferr_nxt;
  logic                 rx_meta, rx_s;

  // Two-flop synchronizer; resets to idle-high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_serial;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      tick_cnt      <= '0;
      bit_cnt       <= '0;
      shift         <= '0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      state         <= state_nxt;
      tick_cnt      <= tick_nxt;
      bit_cnt       <= bit_nxt;
      shift         <= shift_nxt;
      rx_data       <= data_nxt;
      rx_valid      <= valid_nxt;
      framing_error <= ferr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tick_nxt  = tick_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    data_nxt  = rx_data;
    valid_nxt = 1'b0;
    ferr_nxt  = 1'b0;
    if (sample_enable) begin
      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state_nxt = ST_START;
            tick_nxt  = '0;
          end
        end
        ST_START: begin
          if (tick_cnt == TICK_MID) begin
            if (!rx_s) begin
              state_nxt = ST_DATA;
              tick_nxt  = '0;
              bit_nxt   = '0;
            end else begin
              state_nxt = ST_IDLE;
            end
          end else begin
            tick_nxt = tick_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (tick_cnt == TICK_LAST) begin
            shift_nxt = {rx_s, shift[DATA_BITS-1:1]};
            tick_nxt  = '0;
            if (bit_cnt == BIT_LAST) state_nxt = ST_STOP;
            else                     bit_nxt   = bit_cnt + 1'b1;
          end else begin
            tick_nxt = tick_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (tick_cnt == TICK_LAST) begin
            tick_nxt = '0;
            if (rx_s) begin
              data_nxt  = shift;
              valid_nxt = 1'b1;
              state_nxt = ST_IDLE;
            end else begin
              ferr_nxt  = 1'b1;
              state_nxt = ST_BREAK;
            end
          end else begin
            tick_nxt = tick_cnt + 1'b1;
          end
        end
        ST_BREAK: begin
          if (rx_s) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign rx_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer: tick-paced serial driver, byte scoreboard on rx_valid,
// a table of frames followed by hand-written corner-case sequences.
module tb_uart_rx_deserializer;
  localparam int OS = 16;
  localparam int DB = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sample_enable = 1'b0;
  logic          rx_serial = 1'b1;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          framing_error;
  logic          rx_busy;

  int vectors = 0;
  int miscompares = 0;
  int tick_count = 0;
  int div = 0;
  bit tick_en = 1'b1;
  int ferr_seen = 0;
  int ferr_exp = 0;
  logic [DB-1:0] exp_q[$];
  logic [DB-1:0] mon_exp;

  typedef struct {
    logic [DB-1:0] data;
    logic          stop_bit;
    logic [DB-1:0] exp_rx_data;
  } vec_t;

  vec_t vecs[6];

  uart_rx_deserializer #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .clk(clk),
    .reset(reset),
    .sample_enable(sample_enable),
    .rx_serial(rx_serial),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .framing_error(framing_error),
    .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  // One tick every 4 clocks, driven on the falling edge; tick_en pauses it.
  initial begin
    forever begin
      @(negedge clk);
      div = (div + 1) % 4;
      sample_enable = tick_en && (div == 0);
      if (sample_enable) tick_count++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_rx_valid: got data %0h, expected no strobe", rx_data);
        end else begin
          mon_exp = exp_q.pop_front();
          check("rx_data_on_valid", rx_data, mon_exp);
        end
      end
      if (framing_error) begin
        ferr_seen++;
        check("valid_ferr_exclusive", rx_valid, 0);
      end
    end
  end

  task automatic wait_ticks(input int n);
    int target;
    int guard;
    target = tick_count + n;
    guard = 0;
    while (tick_count < target) begin
      @(posedge clk);
      #2;
      guard++;
      if (guard > 20000) begin
        $display("FAIL wait_ticks: no tick progress, got %0d expected %0d", tick_count, target);
        $fatal(1, "tick timeout");
      end
    end
  endtask

  // Leaves rx_serial at stop_bit; caller decides when to release a low stop.
  task automatic send_frame(input logic [DB-1:0] data, input logic stop_bit,
                            input int reset_bit, input int freeze_bit);
    rx_serial = 1'b0;
    wait_ticks(OS);
    check("busy_in_frame", rx_busy, 1);
    for (int i = 0; i < DB; i++) begin
      rx_serial = data[i];
      if (i == reset_bit) begin
        wait_ticks(OS / 2);
        reset = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        rx_serial = 1'b1;
        check("reset_rx_data", rx_data, 0);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_ferr", framing_error, 0);
        check("reset_busy", rx_busy, 0);
        return;
      end
      if (i == freeze_bit) begin
        wait_ticks(5);
        tick_en = 1'b0;
        repeat (50) @(posedge clk);
        #2;
        check("busy_frozen", rx_busy, 1);
        tick_en = 1'b1;
        wait_ticks(OS - 5);
      end else begin
        wait_ticks(OS);
      end
    end
    rx_serial = stop_bit;
    if (stop_bit) exp_q.push_back(data);
    else          ferr_exp++;
    wait_ticks(OS);
    if (stop_bit) check("busy_after_stop", rx_busy, 0);
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 8'hA5};
    vecs[1] = '{8'h5A, 1'b1, 8'h5A};
    vecs[2] = '{8'h3C, 1'b0, 8'h5A};
    vecs[3] = '{8'h01, 1'b1, 8'h01};
    vecs[4] = '{8'h80, 1'b1, 8'h80};
    vecs[5] = '{8'h7E, 1'b1, 8'h7E};

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("init_rx_data", rx_data, 0);
    check("init_rx_valid", rx_valid, 0);
    check("init_ferr", framing_error, 0);
    check("init_busy", rx_busy, 0);
    reset = 1'b0;
    wait_ticks(20);

    foreach (vecs[k]) begin
      send_frame(vecs[k].data, vecs[k].stop_bit, -1, -1);
      rx_serial = 1'b1;
      wait_ticks(8);
      check("table_rx_data", rx_data, vecs[k].exp_rx_data);
      check("table_ferr_count", ferr_seen, ferr_exp);
    end

    // Short low glitch must be rejected at the mid-start sample.
    rx_serial = 1'b0;
    wait_ticks(4);
    rx_serial = 1'b1;
    wait_ticks(OS);
    check("glitch_busy", rx_busy, 0);
    check("glitch_rx_data", rx_data, 8'h7E);
    check("glitch_ferr_count", ferr_seen, ferr_exp);

    // Bad stop followed by a held break: exactly one framing_error.
    send_frame(8'h3C, 1'b0, -1, -1);
    wait_ticks(3 * OS);
    check("break_busy_held", rx_busy, 1);
    rx_serial = 1'b1;
    wait_ticks(OS);
    check("break_released_busy", rx_busy, 0);
    check("break_ferr_count", ferr_seen, ferr_exp);
    check("break_rx_data_held", rx_data, 8'h7E);
    send_frame(8'h81, 1'b1, -1, -1);
    check("after_break_rx_data", rx_data, 8'h81);

    // Back-to-back frames with no idle time.
    send_frame(8'h00, 1'b1, -1, -1);
    send_frame(8'hFF, 1'b1, -1, -1);
    rx_serial = 1'b1;
    wait_ticks(8);
    check("b2b_rx_data", rx_data, 8'hFF);
    check("b2b_queue_drained", exp_q.size(), 0);

    // Reset mid-frame aborts it.
    send_frame(8'h55, 1'b1, 4, -1);
    wait_ticks(2 * OS);
    check("post_reset_rx_data", rx_data, 0);
    send_frame(8'h96, 1'b1, -1, -1);
    rx_serial = 1'b1;
    wait_ticks(8);
    check("after_reset_rx_data", rx_data, 8'h96);

    // Ticks paused mid data bit.
    send_frame(8'hC3, 1'b1, -1, 3);
    rx_serial = 1'b1;
    wait_ticks(8);
    check("freeze_rx_data", rx_data, 8'hC3);

    wait_ticks(OS);
    check("final_queue_empty", exp_q.size(), 0);
    check("final_ferr_count", ferr_seen, ferr_exp);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
- Receive-side counterpart of the UART transmit path.
- Deserializes an 8N1 asynchronous serial stream (1 start, DATA_BITS data LSB-first, 1 stop) using an oversampling tick.
- Presents each received byte with a one-clock valid strobe to the game-logic/command decoder.
- Flags framing errors and holds off until the line returns to idle.

Parameters:
- OVERSAMPLE, 16, sample_enable ticks per bit period; power of two, ≥4.
- DATA_BITS, 8, data bits per frame (5..8).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  reset, synchronous, active-high.
- sample_enable  input  1  oversample tick, one clk wide, rate = baud × OVERSAMPLE.
- rx_serial  input  1  asynchronous serial line; idle high.
- rx_data  output  DATA_BITS  last good byte; stable until next good byte.
- rx_valid  output  1  one-clk pulse: rx_data just updated.
- framing_error  output  1  one-clk pulse: stop bit sampled low.
- rx_busy  output  1  high in any state other than IDLE.

Behaviour:
- Synchronizer: rx_serial passes through 2 flops (reset value 1); FSM sees only the synced line rx_s.
- Reset values: rx_data=0, rx_valid=0, framing_error=0, rx_busy=0, state=IDLE, tick_cnt=0, bit_cnt=0, shift=0.
- Reset asserted mid-frame aborts the frame on the next edge. No strobe is issued, and rx_data keeps its reset value of 0.
- Counters (tick_cnt, bit_cnt) advance only on clk edges where sample_enable=1. With sample_enable low, all state is frozen except the synchronizer.
- IDLE:
  - On a tick with rx_s=0 → START, tick_cnt=0.
- START:
  - Count ticks. At tick_cnt = OVERSAMPLE/2-1 (mid start bit), sample rx_s.
  - If rx_s=0 → DATA, tick_cnt=0, bit_cnt=0.
  - If rx_s=1 → IDLE (glitch reject). No strobe.
- DATA:
  - At tick_cnt = OVERSAMPLE-1, sample rx_s and shift it in at the MSB; shift right, so bits land LSB-first.
  - Then tick_cnt=0 and bit_cnt++.
  - When bit_cnt reaches DATA_BITS-1 and that bit is sampled → STOP.
- STOP:
  - At tick_cnt = OVERSAMPLE-1, sample rx_s.
  - If rx_s=1: rx_data←shift, rx_valid=1 for exactly one clk → IDLE.
  - If rx_s=0: framing_error=1 for exactly one clk, rx_data unchanged → BREAK.
- BREAK:
  - Wait (tick-qualified) until rx_s=1 → IDLE.
  - A line held low (break) produces exactly one framing_error.
- Latency: strobes assert on the clk edge following the stop-bit sampling tick. From the start falling edge this is ≈ (DATA_BITS+1.5) bit periods + 2 clk synchronizer + 1 clk.
- Back-to-back frames: a start bit immediately after stop is accepted. Re-arm in IDLE happens on the first tick after the stop sample, so frames with zero idle time are received.
- rx_valid and framing_error are never high in the same cycle.
- Sampling points: start sample at mid-bit; data/stop samples every OVERSAMPLE ticks thereafter, i.e. mid-bit. No majority voting.
- Mismatched baud: no recovery beyond per-frame resync on each start edge.
- Counter widths:
  - tick_cnt: log2(OVERSAMPLE) bits, wraps to 0 only by explicit clear.
  - bit_cnt: log2(DATA_BITS)+1 bits.

Test Plan:
1. Send 0xA5 at 16 ticks/bit, sample_enable every 4 clk → exactly one rx_valid pulse, rx_data=8'hA5, framing_error never high, rx_busy high from start detect until the strobe cycle.
2. Low glitch on rx_serial lasting 4 ticks in IDLE → return to IDLE at mid-start sample, no rx_valid, no framing_error, rx_data unchanged.
3. Frame 0x3C with stop bit driven 0, line held low for 3 more bit times then released → one framing_error pulse, no rx_valid, rx_data holds previous value, next good frame 0x81 → rx_data=8'h81.
4. Back-to-back 0x00 then 0xFF with zero idle between stop and next start → two rx_valid pulses, values 8'h00 then 8'hFF.
5. Assert reset for 1 clk during data bit 4 of frame 0x55 → no strobe for that frame, outputs return to reset values; following frame 0x96 received correctly.
6. Hold sample_enable low for 50 clk mid-data-bit while rx_serial stays constant → FSM and counters frozen; resuming ticks completes frame 0xC3 with correct value.
